// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the 32x32 register file and its write-back queue.
//   ADDR_W   register address width
//   DATA_W   register data width
//   NUM_REGS number of architectural registers
//   REG_ZERO hard-wired zero register; writes to it are discarded
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wbq_fwd_match.sv
// ----------------------------------------------------------------------------
// wbq_fwd_match
// Youngest-match search over the write-back queue entries for one read port.
// Ports:
//   entry_valid  in   per-entry pending flag
//   entry_addr   in   per-entry destination register
//   entry_data   in   per-entry result value
//   wr_ptr       in   next free slot; wr_ptr-1 is the youngest entry
//   lookup_addr  in   register address presented by the read side
//   hit          out  some pending entry targets lookup_addr
//   data         out  data of the youngest matching entry, 0 on miss
// ----------------------------------------------------------------------------
module wbq_fwd_match #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int DATA_W = regfile_pkg::DATA_W,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]             entry_valid,
   input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
   input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
   input  logic [PTR_W-1:0]             wr_ptr,
   input  logic [ADDR_W-1:0]            lookup_addr,
   output logic                         hit,
   output logic [DATA_W-1:0]            data
);
   import regfile_pkg::REG_ZERO;

   // Walk from the oldest possible slot (wr_ptr-DEPTH) to the youngest
   // (wr_ptr-1); later matches overwrite earlier ones so the youngest wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         idx = wr_ptr - PTR_W'(k);
         if (entry_valid[idx] && (entry_addr[idx] == lookup_addr) &&
             (lookup_addr != ADDR_W'(REG_ZERO))) begin
            hit  = 1'b1;
            data = entry_data[idx];
         end
      end
   end

endmodule

// File: rtl/regfile_writeback_queue.sv
// ----------------------------------------------------------------------------
// regfile_writeback_queue
// Writer side of the register file: an in-order FIFO of results that drains
// at most one entry per cycle onto the register-file write port and forwards
// the youngest pending value for the current rs/rt read addresses.
// Ports:
//   clock              in   rising-edge clock
//   Reset              in   synchronous active-low reset
//   in_valid/in_ready  in/out  producer handshake (in_ready = !full)
//   in_addr, in_data   in   destination register and result value
//   drain_en           in   register file can take a write this cycle
//   reg_write_enable   out  write strobe (head entry retires on this edge)
//   reg_write_address  out  write address, 0 when no write
//   write_data         out  write data, 0 when no write
//   rs_addr, rt_addr   in   read addresses at the register file
//   fwd_hit_1/2        out  pending write targets rs / rt
//   fwd_data_1/2       out  youngest pending data for rs / rt
//   count              out  queue occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module regfile_writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              drain_en,
   output logic              reg_write_enable,
   output logic [ADDR_W-1:0] reg_write_address,
   output logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic              fwd_hit_1,
   output logic              fwd_hit_2,
   output logic [DATA_W-1:0] fwd_data_1,
   output logic [DATA_W-1:0] fwd_data_2,
   output logic [CNT_W-1:0]  count
);
   import regfile_pkg::REG_ZERO;

   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
   logic [DEPTH-1:0][DATA_W-1:0] data_q;
   logic [DEPTH-1:0]             valid_q;
   logic [PTR_W-1:0]             wr_ptr;
   logic [PTR_W-1:0]             rd_ptr;
   logic [CNT_W-1:0]             occ;

   logic full;
   logic empty;
   logic push;
   logic pop;

   assign full     = (occ == CNT_W'(DEPTH));
   assign empty    = (occ == '0);
   assign in_ready = !full;
   assign count    = occ;

   // r0 writes complete the handshake but are never queued.
   assign push = in_valid && in_ready && (in_addr != ADDR_W'(REG_ZERO));

   // Reset gates the strobe so a reset edge never doubles as a retire edge.
   assign pop = !empty && drain_en && Reset;

   assign reg_write_enable  = pop;
   assign reg_write_address = pop ? addr_q[rd_ptr] : '0;
   assign write_data        = pop ? data_q[rd_ptr] : '0;

   always_ff @(posedge clock) begin
      if (!Reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ     <= '0;
         valid_q <= '0;
      end else begin
         // push and pop never touch the same slot: equal pointers imply
         // empty (no pop) or full (no push).
         if (push) begin
            valid_q[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            valid_q[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + CNT_W'(1);
            2'b01:   occ <= occ - CNT_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Payload needs no reset; valid_q and the pointers qualify every read.
   always_ff @(posedge clock) begin
      if (push) begin
         addr_q[wr_ptr] <= in_addr;
         data_q[wr_ptr] <= in_data;
      end
   end

   wbq_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fwd_rs (
      .entry_valid (valid_q),
      .entry_addr  (addr_q),
      .entry_data  (data_q),
      .wr_ptr      (wr_ptr),
      .lookup_addr (rs_addr),
      .hit         (fwd_hit_1),
      .data        (fwd_data_1)
   );

   wbq_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fwd_rt (
      .entry_valid (valid_q),
      .entry_addr  (addr_q),
      .entry_data  (data_q),
      .wr_ptr      (wr_ptr),
      .lookup_addr (rt_addr),
      .hit         (fwd_hit_2),
      .data        (fwd_data_2)
   );

endmodule
